// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// VGA raster timing: Col/Row/valid/hsync/vsync registered together on each pixel tick.
// First tick CLK_DIV clocks after reset release presents (0,0); en=0 freezes everything.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] Col,
    output logic [9:0] Row,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_col_n;
    logic [9:0]       r_row_n;
    logic [9:0]       r_col;
    logic [9:0]       r_row;
    logic             r_valid;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_pix_tick;
    logic             r_frame_start;

    logic             w_tick;
    logic [9:0]       w_col_nxt;
    logic [9:0]       w_row_nxt;
    logic             w_valid;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_origin;

    assign w_tick = en && (r_div == DIV_LAST);

    // Decode of the position about to be presented, plus its successor.
    always_comb begin
        w_col_nxt = r_col_n + 10'd1;
        w_row_nxt = r_row_n;
        if (r_col_n == H_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (r_row_n == V_LAST) ? 10'd0 : r_row_n + 10'd1;
        end
        w_valid  = (r_col_n < H_VIS_C) && (r_row_n < V_VIS_C);
        w_hs_act = (r_col_n >= HS_START) && (r_col_n <= HS_END);
        w_vs_act = (r_row_n >= VS_START) && (r_row_n <= VS_END);
        w_origin = (r_col_n == 10'd0) && (r_row_n == 10'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_col_n       <= '0;
            r_row_n       <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_valid       <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_pix_tick    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_tick    <= w_tick;
            r_frame_start <= w_tick && w_origin;
            if (en) begin
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            end
            if (w_tick) begin
                r_col   <= r_col_n;
                r_row   <= r_row_n;
                r_valid <= w_valid;
                r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
                r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
                r_col_n <= w_col_nxt;
                r_row_n <= w_row_nxt;
            end
        end
    end

    assign Col         = r_col;
    assign Row         = r_row;
    assign valid       = r_valid;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign pix_tick    = r_pix_tick;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: full-size raster (CLK_DIV=2) plus a tiny raster (CLK_DIV=1, active-high sync).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;

    logic [9:0] d_col, d_row, s_col, s_row;
    logic d_valid, d_hs, d_vs, d_tick, d_fs;
    logic s_valid, s_hs, s_vs, s_tick, s_fs;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .Col(d_col), .Row(d_row), .valid(d_valid), .hsync(d_hs), .vsync(d_vs),
        .pix_tick(d_tick), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .en(en),
        .Col(s_col), .Row(s_row), .valid(s_valid), .hsync(s_hs), .vsync(s_vs),
        .pix_tick(s_tick), .frame_start(s_fs)
    );

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       valid;
        logic       hs;
        logic       vs;
        logic       tick;
        logic       fs;
    } obs_t;

    // Reference: count enabled clock edges since reset; every CLK_DIV-th one presents the next pixel.
    function automatic obs_t model(int e, bit last_en, int div,
                                   int hv, int hfp, int hsy, int hbp,
                                   int vv, int vfp, int vsy, int vbp, bit pol);
        obs_t x;
        int ht, vt, n, p, c, r;
        ht = hv + hfp + hsy + hbp;
        vt = vv + vfp + vsy + vbp;
        n  = e / div;
        x.tick = last_en && (e > 0) && (e % div == 0);
        if (n == 0) begin
            x.col = '0; x.row = '0; x.valid = 1'b0;
            x.hs = ~pol; x.vs = ~pol; x.fs = 1'b0;
        end else begin
            p = n - 1;
            c = p % ht;
            r = (p / ht) % vt;
            x.col   = 10'(c);
            x.row   = 10'(r);
            x.valid = (c < hv) && (r < vv);
            x.hs    = (c >= hv + hfp && c < hv + hfp + hsy) ? pol : ~pol;
            x.vs    = (r >= vv + vfp && r < vv + vfp + vsy) ? pol : ~pol;
            x.fs    = x.tick && (c == 0) && (r == 0);
        end
        return x;
    endfunction

    int e_cnt   = 0;
    bit last_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt   = 0;
            last_en = 1'b0;
        end else begin
            last_en = en;
            if (en) e_cnt = e_cnt + 1;
        end
    end

    int n_printed = 0;

    always @(negedge clk) begin
        obs_t xd, xs, ad, as_;
        xd  = model(e_cnt, last_en, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
        xs  = model(e_cnt, last_en, 1, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1);
        ad  = {d_col, d_row, d_valid, d_hs, d_vs, d_tick, d_fs};
        as_ = {s_col, s_row, s_valid, s_hs, s_vs, s_tick, s_fs};
        n_checks = n_checks + 2;
        if (ad !== xd) begin
            n_err = n_err + 1;
            if (n_printed < 20) begin
                n_printed = n_printed + 1;
                $display("FAIL model_full t=%0t got col=%0d row=%0d v=%b hs=%b vs=%b tick=%b fs=%b expected col=%0d row=%0d v=%b hs=%b vs=%b tick=%b fs=%b",
                         $time, ad.col, ad.row, ad.valid, ad.hs, ad.vs, ad.tick, ad.fs,
                         xd.col, xd.row, xd.valid, xd.hs, xd.vs, xd.tick, xd.fs);
            end
        end
        if (as_ !== xs) begin
            n_err = n_err + 1;
            if (n_printed < 20) begin
                n_printed = n_printed + 1;
                $display("FAIL model_small t=%0t got col=%0d row=%0d v=%b hs=%b vs=%b tick=%b fs=%b expected col=%0d row=%0d v=%b hs=%b vs=%b tick=%b fs=%b",
                         $time, as_.col, as_.row, as_.valid, as_.hs, as_.vs, as_.tick, as_.fs,
                         xs.col, xs.row, xs.valid, xs.hs, xs.vs, xs.tick, xs.fs);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_d_tick(input int max_clks, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_clks; i++) begin
            @(negedge clk);
            if (d_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("timeout_d_tick", 0, 1);
    endtask

    task automatic release_and_check_first;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("pre_tick_none", d_tick, 0);
        @(negedge clk);
        chk("first_clk_no_tick", d_tick, 0);
        chk("small_first_fs", s_fs, 1);
        @(negedge clk);
        chk("first_tick", d_tick, 1);
        chk("first_col", d_col, 0);
        chk("first_row", d_row, 0);
        chk("first_valid", d_valid, 1);
        chk("first_fs", d_fs, 1);
    endtask

    initial begin
        bit ok;
        int nt, nv, nh, clk_since;
        int pc, pr, st, sv, shs, svs, sfs;

        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_col", d_col, 0);
        chk("rst_valid", d_valid, 0);
        chk("rst_hsync", d_hs, 1);
        chk("rst_vsync", d_vs, 1);

        release_and_check_first();

        // One full line of the 800-pixel raster.
        nt = 1; nv = 1; nh = 0; clk_since = 0;
        for (int i = 0; i < 2000 && nt < 800; i++) begin
            @(negedge clk);
            clk_since = clk_since + 1;
            if (d_tick === 1'b1) begin
                nt = nt + 1;
                if (d_valid === 1'b1) nv = nv + 1;
                if (d_hs === 1'b0) nh = nh + 1;
                if (nt == 2) begin
                    chk("second_col", d_col, 1);
                    chk("second_gap", clk_since, 2);
                end
            end
        end
        chk("line_ticks", nt, 800);
        chk("line_valid", nv, 640);
        chk("line_hsync_low", nh, 96);
        chk("line_last_col", d_col, 799);
        chk("line_last_row", d_row, 0);
        wait_d_tick(4, ok);
        chk("wrap_col", d_col, 0);
        chk("wrap_row", d_row, 1);
        chk("wrap_valid", d_valid, 1);

        // Tiny raster: one complete frame, measured frame_start to frame_start.
        ok = 1'b0; pc = -1; pr = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_fs === 1'b1) begin
                ok = 1'b1;
                break;
            end
            pc = s_col; pr = s_row;
        end
        chk("small_fs_seen", ok, 1);
        chk("small_prev_col", pc, 14);
        chk("small_prev_row", pr, 9);
        chk("small_fs_col", s_col, 0);
        chk("small_fs_row", s_row, 0);
        st = 0; sv = 0; shs = 0; svs = 0; sfs = 0;
        for (int i = 0; i < 150; i++) begin
            if (i > 0) @(negedge clk);
            if (s_tick === 1'b1) st = st + 1;
            if (s_valid === 1'b1) sv = sv + 1;
            if (s_hs === 1'b1) shs = shs + 1;
            if (s_vs === 1'b1) svs = svs + 1;
            if (s_fs === 1'b1) sfs = sfs + 1;
        end
        chk("small_ticks", st, 150);
        chk("small_valid", sv, 48);
        chk("small_hsync", shs, 30);
        chk("small_vsync", svs, 30);
        chk("small_fs_count", sfs, 1);
        @(negedge clk);
        chk("small_next_fs", s_fs, 1);

        // Enable stall at Col=100.
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (d_tick === 1'b1 && d_col == 10'd100) begin
                ok = 1'b1;
                break;
            end
        end
        chk("stall_reach_100", ok, 1);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("stall_col_hold", d_col, 100);
            chk("stall_no_tick", d_tick, 0);
        end
        en = 1'b1;
        wait_d_tick(4, ok);
        chk("resume_col", d_col, 101);

        // Asynchronous reset mid-line, observed between clock edges.
        repeat (37) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_col", d_col, 0);
        chk("arst_row", d_row, 0);
        chk("arst_valid", d_valid, 0);
        chk("arst_hsync", d_hs, 1);
        chk("arst_vsync", d_vs, 1);
        chk("arst_tick", d_tick, 0);
        repeat (2) @(negedge clk);
        release_and_check_first();
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
